// File: rtl/spi_rx.sv
// spi_rx: SPI peripheral-side receive shifter.
// Oversamples sclk/rxd/cs_n on clk, deserialises MSB-first words and presents
// each completed word on an AXI-Stream master port with a one-word holding
// register. Flags dropped words (overrun) and partial words at cs_n release
// (framing).
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   sclk, rxd, cs_n   raw SPI inputs, asynchronous to clk
//   spi_mode          SPI mode 0..3, latched at frame start
//   m_axis_*          received-word stream (tdata/tvalid out, tready in)
//   busy              high while a frame is selected
//   overrun_error     one-cycle pulse when a completed word is dropped
//   frame_error       one-cycle pulse when cs_n releases mid-word
module spi_rx #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  rxd,
    input  logic                  cs_n,
    input  logic [1:0]            spi_mode,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, rxd_sync_q, cs_sync_q;
    logic                    sclk_prev_q;
    logic [1:0]              mode_q, mode_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    ovr_q, ovr_d;
    logic                    ferr_q, ferr_d;

    logic sclk_s_c, rxd_s_c, cs_s_c;
    logic rise_c, fall_c, sample_edge_c, word_done_c;

    // Synchronisers: identical depth keeps sclk/rxd/cs_n mutually aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            rxd_sync_q  <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            rxd_sync_q  <= {rxd_sync_q[SYNC_STAGES-2:0], rxd};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s_c = sclk_sync_q[SYNC_STAGES-1];
    assign rxd_s_c  = rxd_sync_q[SYNC_STAGES-1];
    assign cs_s_c   = cs_sync_q[SYNC_STAGES-1];
    assign rise_c   = sclk_s_c & ~sclk_prev_q;
    assign fall_c   = ~sclk_s_c & sclk_prev_q;
    // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge
    assign sample_edge_c = (mode_q[1] == mode_q[0]) ? rise_c : fall_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!cs_s_c) state_d = RECV;
            RECV: if (cs_s_c)  state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        mode_d      = mode_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q & ~m_axis_tready;
        ovr_d       = 1'b0;
        ferr_d      = 1'b0;
        word_done_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cs_s_c) begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    mode_d    = spi_mode;
                end
            end
            RECV: begin
                // cs_n release wins over a coincident sample edge
                if (cs_s_c) begin
                    if (bit_cnt_q != '0) ferr_d = 1'b1;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end else if (sample_edge_c) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], rxd_s_c};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d   = '0;
                        word_done_c = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
        // Holding register accepts a word when empty or being drained this cycle
        if (word_done_c) begin
            if (!tvalid_q || m_axis_tready) begin
                tdata_d  = shift_d;
                tvalid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            mode_q    <= 2'd0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            mode_q    <= mode_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = (state_q == RECV);
    assign overrun_error = ovr_q;
    assign frame_error   = ferr_q;

endmodule
